// File: rtl/updown_count_ctrl.sv
// updown_count_ctrl: command-driven sequencer for a modulo-i up/down counter.
// Accepts one "count N steps up/down" command at a time, steps once per clock,
// and reports wrap events and completion.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_dir, cmd_steps    1 = up / 0 = down, number of steps
//   abort                 cancel a running command (count held, no done)
//   pause                 stall a running command (only with COUNT_CTRL_PAUSE_EN)
//   count                 current count value, 0..i-1
//   busy, wrap, done      running flag, wrap pulse, completion pulse
// Optional feature macro: COUNT_CTRL_PAUSE_EN adds the pause input.
module updown_count_ctrl #(
    parameter int width  = 4,
    parameter int i      = 5,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic              abort,
`ifdef COUNT_CTRL_PAUSE_EN
    input  logic              pause,
`endif
    output logic [width-1:0]  count,
    output logic              busy,
    output logic              wrap,
    output logic              done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [width-1:0] MAX = width'(i - 1);

    state_t            state_q, state_d;
    logic [width-1:0]  count_q, count_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              dir_q, dir_d;
    logic              busy_q, busy_d;
    logic              wrap_q, wrap_d;
    logic              done_q, done_d;
    logic              hold;

`ifdef COUNT_CTRL_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign count     = count_q;
    assign busy      = busy_q;
    assign wrap      = wrap_q;
    assign done      = done_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid && cmd_ready) begin
                dir_d   = cmd_dir;
                rem_d   = cmd_steps;
                state_d = (cmd_steps == '0) ? DONE : RUN;
            end
            RUN: if (abort) begin
                state_d = IDLE;
                rem_d   = '0;
            end else if (!hold) begin
                count_d = dir_q ? ((count_q == MAX) ? '0 : count_q + 1'b1)
                                : ((count_q == '0) ? MAX : count_q - 1'b1);
                wrap_d  = dir_q ? (count_q == MAX) : (count_q == '0);
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == 1) ? DONE : RUN;
            end
            // DONE spans two cycles: the first raises the registered done pulse,
            // the second (pulse visible) returns to IDLE.
            DONE: begin
                done_d  = !done_q;
                state_d = done_q ? IDLE : DONE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_updown_count_ctrl.sv
// tb_updown_count_ctrl: randomized and directed check of updown_count_ctrl against a timing-level model.
module tb_updown_count_ctrl;
    localparam int W = 4, M = 5, SW = 8;

    logic          clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_dir = 1'b0, abort = 1'b0;
    logic [SW-1:0] cmd_steps = '0;
`ifdef COUNT_CTRL_PAUSE_EN
    logic          pause = 1'b0;
`endif
    logic          cmd_ready, busy, wrap, done;
    logic [W-1:0]  count;
    int            n_cmp = 0, n_err = 0;
    int            mc = 0;

    always #5 clk = ~clk;

    updown_count_ctrl #(.width(W), .i(M), .STEP_W(SW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .abort(abort),
`ifdef COUNT_CTRL_PAUSE_EN
        .pause(pause),
`endif
        .count(count), .busy(busy), .wrap(wrap), .done(done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int next_val(input int c, input bit up);
        return up ? (c + 1) % M : (c + M - 1) % M;
    endfunction

    function automatic bit crosses(input int c, input bit up);
        return up ? (c == M - 1) : (c == 0);
    endfunction

    // abort_at: abort raised once this many steps are taken (-1 = never)
    // pause_at: two pause cycles once this many steps are taken (-1 = never)
    // ab_done : raise abort during the completion cycle, where it must be ignored
    task automatic run_cmd(input bit up, input int n, input int abort_at, input int pause_at, input bit ab_done);
        int  waited = 0, taken = 0, post = 0, pcnt = 0, busy_cnt = 0;
        bit  fin = (n == 0), ended = 0, pz, ab, ew;
        while (!cmd_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        check("ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_dir = up; cmd_steps = SW'(n);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("acc_busy", busy, n > 0);
        check("acc_ready", cmd_ready, 0);
        check("acc_count", count, mc);
        check("acc_done", done, 0);
        busy_cnt += busy;
        for (int g = 0; g < 600 && !ended; g++) begin
            ab = (!fin && abort_at >= 0 && taken == abort_at) || (fin && post == 0 && ab_done);
            pz = !fin && !ab && pause_at >= 0 && taken == pause_at && pcnt < 2;
            abort = ab;
`ifdef COUNT_CTRL_PAUSE_EN
            pause = pz;
`endif
            @(posedge clk); #1;
            abort = 1'b0;
`ifdef COUNT_CTRL_PAUSE_EN
            pause = 1'b0;
`endif
            if (fin) begin
                post++;
                check("count", count, mc);
                check("wrap", wrap, 0);
                check("busy", busy, 0);
                check("done", done, post == 1);
                check("ready", cmd_ready, post == 2);
                ended = (post == 2);
            end else if (ab) begin
                check("abort_count", count, mc);
                check("abort_busy", busy, 0);
                check("abort_ready", cmd_ready, 1);
                check("abort_done", done, 0);
                @(posedge clk); #1;
                check("abort_nodone", done, 0);
                ended = 1;
            end else begin
                if (pz) begin
                    pcnt++;
                    ew = 0;
                end else begin
                    ew = crosses(mc, up);
                    mc = next_val(mc, up);
                    taken++;
                    fin = (taken == n);
                end
                check("count", count, mc);
                check("wrap", wrap, ew);
                check("busy", busy, !fin);
                check("done", done, 0);
                check("ready", cmd_ready, 0);
                busy_cnt += busy;
            end
        end
        check("cmd_end", ended, 1);
        if (abort_at < 0) check("busy_cycles", busy_cnt, n + pcnt);
    endtask

    initial begin
        int n, ab_at;
        #12;
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_wrap", wrap, 0);
        check("rst_done", done, 0);
        check("rst_ready", cmd_ready, 0);
        @(negedge clk); rst = 1'b0; #1;
        check("rel_ready", cmd_ready, 1);
        mc = 0;
        run_cmd(1, 3, -1, -1, 0);
        check("t2_final", count, 3);
        run_cmd(0, 3, -1, -1, 0);
        run_cmd(1, 7, -1, -1, 0);
        check("t3_final", count, 2);
        run_cmd(0, 2, -1, -1, 0);
        run_cmd(0, 2, -1, -1, 0);
        check("t4_final", count, 3);
        run_cmd(1, 0, -1, -1, 1);
        check("t5_final", count, 3);
        run_cmd(1, 2, -1, -1, 0);
        run_cmd(1, 5, 2, -1, 0);
        check("t6_final", count, 2);
`ifdef COUNT_CTRL_PAUSE_EN
        run_cmd(1, 6, -1, 3, 0);
        run_cmd(0, 6, 4, 2, 0);
`endif
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(0, 12);
            ab_at = (n > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
`ifdef COUNT_CTRL_PAUSE_EN
            run_cmd($urandom_range(0, 1) == 1, n, ab_at,
                    (n > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1,
                    $urandom_range(0, 3) == 0);
`else
            run_cmd($urandom_range(0, 1) == 1, n, ab_at, -1, $urandom_range(0, 3) == 0);
`endif
        end
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = SW'(9);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_ready", cmd_ready, 0);
        @(negedge clk); rst = 1'b0; #1;
        check("arst_rel_ready", cmd_ready, 1);
        mc = 0;
        repeat (3) begin
            @(posedge clk); #1;
            check("arst_nodone", done, 0);
        end
        run_cmd(0, 1, -1, -1, 0);
        check("post_rst_final", count, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
